// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one data RAM/I-O port between the CPU MEM stage
// and a DMA engine. The CPU normally wins. A DMA request that has waited
// STARVE_LIMIT cycles beats the CPU. Once a DMA burst starts, it keeps the
// bus until dma_last, until BURST_MAX beats, or until the DMA drops its request.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_IDLE      | no burst in progress; CPU has priority unless DMA is starved
// ST_DMA_BURST | DMA holds the bus; each cycle with dma_req=1 is one more beat

module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic        clock,
    input  logic        reset,
    // CPU (pipeline MEM stage)
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    // DMA engine
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_last,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    // shared memory port, 1-cycle read latency
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int BW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BEAT_MAX   = BW'(BURST_MAX);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_DMA_BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [BW-1:0]  beat_inc;
    logic           cpu_ack_q;
    logic           dma_rvalid_q;
    logic           cpu_gnt;
    logic           dma_gnt_c;

    assign beat_inc = beat_q + BW'(1);

    // Grant decision, next FSM state and next counter values, all from the current state and request inputs.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt_c = 1'b0;
        state_d   = state_q;
        beat_d    = beat_q;
        starve_d  = starve_q;

        case (state_q)
            ST_IDLE: begin
                if (dma_req && (!cpu_req || starve_q == STARVE_MAX)) begin
                    dma_gnt_c = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end
                if (dma_gnt_c && !dma_last && (BURST_MAX > 1)) begin
                    state_d = ST_DMA_BURST;
                    beat_d  = BW'(1);
                end
            end
            ST_DMA_BURST: begin
                if (dma_req) begin
                    dma_gnt_c = 1'b1;
                    if (dma_last || beat_inc == BEAT_MAX) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_inc;
                    end
                end else begin
                    // DMA aborted mid-burst: release the bus without a grant
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase

        // Starvation only accumulates while the DMA is actually waiting
        if (dma_gnt_c || !dma_req) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // FSM, counters and registered completion flags; reset drops any burst silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            beat_q       <= '0;
            cpu_ack_q    <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            beat_q       <= beat_d;
            cpu_ack_q    <= cpu_gnt;
            dma_rvalid_q <= dma_gnt_c && !dma_we;
        end
    end

    // Memory port follows the granted requester in the same cycle, zero when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt_c) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_stall  = cpu_req && !cpu_gnt;
    assign dma_gnt    = dma_gnt_c;
    assign cpu_ack    = cpu_ack_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with default parameters (STARVE_LIMIT=4, BURST_MAX=8).
// Inputs change 1 time unit after the rising edge. Combinational outputs are
// sampled 1 unit after that. Registered outputs are sampled just after the edge.

module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_ack;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_last;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_last  (dma_last),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_rdata (dma_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n cycles with both requesters active where the CPU is expected to win
    task automatic cpu_phase(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("phase_cpu_stall", 32'(cpu_stall), 32'(0));
            chk("phase_dma_gnt", 32'(dma_gnt), 32'(0));
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_last = 0; dma_addr = 0; dma_wdata = 0;
        mem_rdata = 0;
        tick();
        tick();

        // reset state
        chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'(0));
        reset = 1'b0;
        #1;
        chk("idle_dma_gnt", 32'(dma_gnt), 32'(0));
        chk("idle_cpu_stall", 32'(cpu_stall), 32'(0));
        chk("idle_mem_addr", mem_addr, 32'h0);
        tick();

        // CPU read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hCAFE0001;
        #1;
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_cpu_stall", 32'(cpu_stall), 32'(0));
        chk("rd_mem_we", 32'(mem_we), 32'(0));
        tick();
        cpu_req = 0;
        chk("rd_cpu_ack", 32'(cpu_ack), 32'(1));
        chk("rd_cpu_rdata", cpu_rdata, 32'hCAFE0001);
        #1;
        chk("nogrant_mem_addr", mem_addr, 32'h0);
        tick();
        chk("rd_ack_one_cycle", 32'(cpu_ack), 32'(0));

        // CPU write
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD0020;
        #1;
        chk("wr_mem_we", 32'(mem_we), 32'(1));
        chk("wr_mem_addr", mem_addr, 32'h20);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD0020);
        tick();
        chk("wr_cpu_ack", 32'(cpu_ack), 32'(1));
        cpu_we = 0;

        // Both requesters held: 4 CPU grants then 1 DMA grant, repeating
        dma_req = 1; dma_we = 1; dma_last = 1; dma_addr = 32'h100; dma_wdata = 32'h5A5A0100;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("fair_dma_gnt", 32'(dma_gnt), 32'((i % 5) == 4));
            chk("fair_cpu_stall", 32'(cpu_stall), 32'((i % 5) == 4));
            chk("fair_mem_addr", mem_addr, ((i % 5) == 4) ? 32'h100 : 32'h20);
            tick();
            chk("fair_cpu_ack", 32'(cpu_ack), 32'((i % 5) != 4));
            chk("fair_dma_rvalid_wr", 32'(dma_rvalid), 32'(0));
        end
        cpu_req = 0; dma_req = 0; dma_last = 0;
        tick();

        // 3-beat DMA write burst while the CPU waits
        cpu_req = 1; dma_req = 1; dma_we = 1; dma_last = 0;
        cpu_phase(4);
        for (int b = 1; b <= 3; b++) begin
            dma_last = (b == 3);
            dma_addr = 32'h200 + 32'(4 * b);
            #1;
            chk("b3_dma_gnt", 32'(dma_gnt), 32'(1));
            chk("b3_cpu_stall", 32'(cpu_stall), 32'(1));
            chk("b3_mem_addr", mem_addr, 32'h200 + 32'(4 * b));
            chk("b3_mem_we", 32'(mem_we), 32'(1));
            tick();
            chk("b3_cpu_ack", 32'(cpu_ack), 32'(0));
            chk("b3_dma_rvalid", 32'(dma_rvalid), 32'(0));
        end
        dma_req = 0; dma_last = 0;
        #1;
        chk("b3_after_cpu_stall", 32'(cpu_stall), 32'(0));
        tick();
        chk("b3_after_cpu_ack", 32'(cpu_ack), 32'(1));

        // DMA read burst without dma_last: forced end after 8 beats
        dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h300;
        cpu_phase(4);
        for (int b = 1; b <= 8; b++) begin
            mem_rdata = 32'hBEEF0000 | 32'(b);
            #1;
            chk("b8_dma_gnt", 32'(dma_gnt), 32'(1));
            chk("b8_cpu_stall", 32'(cpu_stall), 32'(1));
            chk("b8_mem_we", 32'(mem_we), 32'(0));
            tick();
            chk("b8_dma_rvalid", 32'(dma_rvalid), 32'(1));
            chk("b8_dma_rdata", dma_rdata, 32'hBEEF0000 | 32'(b));
        end
        #1;
        chk("b8_forced_end_dma_gnt", 32'(dma_gnt), 32'(0));
        chk("b8_forced_end_cpu_stall", 32'(cpu_stall), 32'(0));
        tick();
        chk("b8_forced_end_cpu_ack", 32'(cpu_ack), 32'(1));
        chk("b8_forced_end_rvalid", 32'(dma_rvalid), 32'(0));
        cpu_req = 0; dma_req = 0;
        tick();

        // Abort: dma_req dropped on beat 2
        cpu_req = 1; dma_req = 1; dma_last = 0; dma_addr = 32'h400;
        cpu_phase(4);
        #1;
        chk("abort_beat1_gnt", 32'(dma_gnt), 32'(1));
        tick();
        dma_req = 0;
        #1;
        chk("abort_dma_gnt", 32'(dma_gnt), 32'(0));
        chk("abort_cpu_stall", 32'(cpu_stall), 32'(1));
        chk("abort_mem_addr", mem_addr, 32'h0);
        tick();
        #1;
        chk("abort_idle_cpu_stall", 32'(cpu_stall), 32'(0));
        tick();
        chk("abort_idle_cpu_ack", 32'(cpu_ack), 32'(1));

        // Reset asserted on beat 5 of a DMA read burst
        dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h500;
        cpu_phase(4);
        for (int b = 1; b <= 4; b++) begin
            #1;
            chk("rb_dma_gnt", 32'(dma_gnt), 32'(1));
            tick();
        end
        reset = 1;
        #1;
        chk("rb_reset_cycle_dma_gnt", 32'(dma_gnt), 32'(1));
        tick();
        reset = 0;
        chk("rb_dma_rvalid", 32'(dma_rvalid), 32'(0));
        chk("rb_cpu_ack", 32'(cpu_ack), 32'(0));
        #1;
        chk("rb_idle_dma_gnt", 32'(dma_gnt), 32'(0));
        chk("rb_idle_cpu_stall", 32'(cpu_stall), 32'(0));
        tick();
        chk("rb_idle_cpu_ack", 32'(cpu_ack), 32'(1));
        cpu_req = 0; dma_req = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
